fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_buf.sv | 43 ++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned ILEN_BYTES = 4;

  // Clears the byte-offset bits of an address so it points at a whole word.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(ILEN_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  // Sequential next fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] a);
    return a + XLEN'(ILEN_BYTES);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer between instruction memory and decode.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic         i_ready,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  // Occupancy: a flush wins, a refill wins over a same-cycle consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only changes on a real load, so a stalled entry stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (i_load && !i_flush) begin
      r_entry <= i_entry;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc sequencing, single outstanding memory request,
// branch redirect with response dropping, and a one-entry decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jreq,
  input  logic [XLEN-1:0]   jval,
  output logic              ireq,
  output logic [XLEN-1:0]   iaddr,
  input  logic              igrant,
  input  logic              iack,
  input  logic [INST_W-1:0] idata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;

  logic         w_ireq;
  logic         w_grant;
  logic         w_load;
  logic         w_buf_valid;
  fetch_entry_t w_buf_entry;
  fetch_entry_t w_load_entry;

  assign w_grant = w_ireq & igrant;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a redirect turns any in-flight response into one to drop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_grant) begin
          w_state_nxt = jreq ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (iack) begin
          w_state_nxt = ST_REQ;
        end else if (jreq) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (iack) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: request only when the buffer has room (or is draining now).
  always_comb begin
    w_ireq = 1'b0;
    w_load = 1'b0;
    case (r_state)
      ST_REQ:  w_ireq = !w_buf_valid || inst_ready;
      ST_WAIT: w_load = iack && !jreq;
      default: begin
        w_ireq = 1'b0;
        w_load = 1'b0;
      end
    endcase
  end

  // Program counter: redirect has priority over sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (jreq) begin
      r_pc <= word_align(jval);
    end else if (w_grant) begin
      r_pc <= pc_incr(r_pc);
    end
  end

  // Address of the request currently in flight, tagged onto its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_pc <= RESET_PC;
    end else if (w_grant) begin
      r_req_pc <= r_pc;
    end
  end

  assign w_load_entry = '{inst: idata, pc: r_req_pc};

  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (jreq),
    .i_ready (inst_ready),
    .i_entry (w_load_entry),
    .o_valid (w_buf_valid),
    .o_entry (w_buf_entry)
  );

  assign ireq       = w_ireq;
  assign iaddr      = r_pc;
  assign inst_valid = w_buf_valid;
  assign inst       = w_buf_entry.inst;
  assign inst_pc    = w_buf_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all checked against a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        jreq;
  logic [31:0] jval;
  logic        ireq;
  logic [31:0] iaddr;
  logic        igrant;
  logic        iack;
  logic [31:0] idata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .jreq       (jreq),
    .jval       (jval),
    .ireq       (ireq),
    .iaddr      (iaddr),
    .igrant     (igrant),
    .iack       (iack),
    .idata      (idata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: next address to request, next address decode should see.
  logic [31:0] fetch_ptr;
  logic [31:0] exp_pc;
  logic [31:0] mem_addr;
  bit          outstanding;
  int          mem_cnt;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          prev_jreq;
  bit          prev_hold;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc;
  logic [31:0] grant_log[$];
  logic [31:0] deliv_log[$];
  int          cyc = 0;
  int          first_grant_cyc = -1;
  int          first_valid_cyc = -1;
  int          n_deliv = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] gl(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dl(input int i);
    if (i < deliv_log.size()) return deliv_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fetch_ptr   = RST_PC;
    exp_pc      = RST_PC;
    outstanding = 1'b0;
    mem_cnt     = 0;
    prev_jreq   = 1'b0;
    prev_hold   = 1'b0;
    iack        = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    deliv_log.delete();
    first_grant_cyc = -1;
    first_valid_cyc = -1;
  endtask

  // Drive one cycle of inputs; the memory answers a grant after mem_cnt cycles.
  task automatic drive(input bit g, input bit j, input logic [31:0] jv, input bit rdy);
    igrant     = g;
    jreq       = j;
    jval       = jv;
    inst_ready = rdy;
    if (outstanding) begin
      mem_cnt--;
      iack = (mem_cnt == 0);
    end else begin
      iack = 1'b0;
    end
    idata = iack ? memfn(mem_addr) : $urandom;
  endtask

  // Per-cycle transaction checks, sampled mid-cycle.
  task automatic model_cycle();
    cyc++;
    if (prev_jreq) chk1("flush_on_jreq", inst_valid, 1'b0);
    if (prev_hold) begin
      chk1("hold_valid", inst_valid, 1'b1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_pc", inst_pc, prev_pc);
    end
    if (inst_valid && !inst_ready) chk1("ireq_gated", ireq, 1'b0);
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (iack) outstanding = 1'b0;
    if (ireq && igrant) begin
      chk1("single_outstanding", outstanding, 1'b0);
      chk("grant_addr", iaddr, fetch_ptr);
      grant_log.push_back(iaddr);
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      outstanding = 1'b1;
      mem_addr    = iaddr;
      mem_cnt     = int'($urandom_range(lat_max, lat_min));
      fetch_ptr   = fetch_ptr + 32'd4;
    end
    if (inst_valid && inst_ready) begin
      chk("deliver_pc", inst_pc, exp_pc);
      chk("deliver_inst", inst, memfn(exp_pc));
      deliv_log.push_back(inst_pc);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (jreq) begin
      fetch_ptr = jval & ~32'd3;
      exp_pc    = jval & ~32'd3;
    end
    prev_jreq = jreq;
    prev_hold = inst_valid && !inst_ready && !jreq;
    prev_inst = inst;
    prev_pc   = inst_pc;
  endtask

  task automatic step(input bit g, input bit j, input logic [31:0] jv, input bit rdy);
    @(posedge clk);
    #1;
    drive(g, j, jv, rdy);
    @(negedge clk);
    model_cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk1("idle_no_req", ireq, 1'b0);
    model_cycle();
  endtask

  // Let any in-flight response land and park in REQ with an empty buffer.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (!outstanding && ireq) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drain_timeout", ok, 1'b1);
  endtask

  task automatic run_until_deliv(input int n, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (deliv_log.size() >= n) break;
      step(1'b1, 1'b0, 32'h0, 1'b1);
    end
    chk1(tag, deliv_log.size() >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst        = 1'b1;
    jreq       = 1'b0;
    jval       = 32'h0;
    igrant     = 1'b0;
    iack       = 1'b0;
    idata      = 32'h0;
    inst_ready = 1'b0;
    model_reset();
    clear_logs();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_ireq", ireq, 1'b0);
    chk("rst_iaddr", iaddr, RST_PC);
    chk1("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Straight-line fetch from reset
    release_reset();
    run_until_deliv(3, "seq_timeout");
    chk("seq_iaddr0", gl(0), 32'h0);
    chk("seq_iaddr1", gl(1), 32'h4);
    chk("seq_iaddr2", gl(2), 32'h8);
    chk("seq_pc0", dl(0), 32'h0);
    chk("seq_pc1", dl(1), 32'h4);
    chk("seq_pc2", dl(2), 32'h8);
    chk("grant_to_valid", 32'(first_valid_cyc - first_grant_cyc), 32'd2);

    // Grant withheld: address held, one request granted
    drain();
    step(1'b0, 1'b1, 32'h10, 1'b1);
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk1("stall_ireq", ireq, 1'b1);
      chk("stall_iaddr", iaddr, 32'h10);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_grants", 32'(grant_log.size()), 32'd1);
    chk("stall_grant_addr", gl(0), 32'h10);

    // Redirect while waiting: response dropped
    drain();
    step(1'b0, 1'b1, 32'h20, 1'b1);
    lat_min = 3;
    lat_max = 3;
    clear_logs();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h103, 1'b1);
    run_until_deliv(1, "wait_jreq_timeout");
    chk("wait_jreq_old", gl(0), 32'h20);
    chk("wait_jreq_new", gl(1), 32'h100);
    chk("wait_jreq_pc", dl(0), 32'h100);

    // Redirect in the same cycle as the response
    drain();
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b1, 32'h8, 1'b1);
    clear_logs();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("ack_jreq_ireq", ireq, 1'b1);
    chk("ack_jreq_iaddr", iaddr, 32'h40);
    chk1("ack_jreq_valid", inst_valid, 1'b0);
    run_until_deliv(1, "ack_jreq_timeout");
    chk("ack_jreq_pc", dl(0), 32'h40);

    // Decode back-pressure
    drain();
    step(1'b0, 1'b1, 32'hC, 1'b1);
    clear_logs();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk1("bp_valid", inst_valid, 1'b1);
      chk("bp_pc", inst_pc, 32'hC);
      chk("bp_inst", inst, memfn(32'hC));
      chk1("bp_ireq", ireq, 1'b0);
    end
    run_until_deliv(2, "bp_timeout");
    chk("bp_pc0", dl(0), 32'hC);
    chk("bp_pc1", dl(1), 32'h10);

    // Asynchronous reset while a request is outstanding
    drain();
    lat_min = 3;
    lat_max = 3;
    step(1'b0, 1'b1, 32'h30, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    #2;
    rst  = 1'b1;
    iack = 1'b0;
    #1;
    chk1("arst_ireq", ireq, 1'b0);
    chk("arst_iaddr", iaddr, RST_PC);
    chk1("arst_valid", inst_valid, 1'b0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    model_reset();
    clear_logs();
    lat_min = 1;
    lat_max = 1;
    @(posedge clk);
    release_reset();
    run_until_deliv(2, "restart_timeout");
    chk("restart_iaddr", gl(0), RST_PC);
    chk("restart_pc0", dl(0), RST_PC);
    chk("restart_pc1", dl(1), RST_PC + 32'd4);

    // Randomized traffic
    lat_min = 1;
    lat_max = 4;
    n0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 4, $urandom,
           $urandom_range(99, 0) < 75);
    end
    chk1("random_progress", (n_deliv - n0) > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
